// File: rtl/branch_chooser_pkg.sv
// branch_chooser_pkg: shared state encoding, counter constants and PC index helper
package branch_chooser_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CNT_MAX  = 2'd3;
  localparam logic [1:0] CNT_MIN  = 2'd0;
  localparam logic [1:0] CNT_INIT = 2'b01;

  // Word-aligned PC bits; callers truncate to their own index width.
  function automatic logic [29:0] pc_index(input logic [31:0] pc);
    return pc[31:2];
  endfunction

endpackage

// File: rtl/branch_chooser_sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter (inc, dec or hold)
module sat_counter2
  import branch_chooser_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] nxt
);

  // Conflicting or absent requests hold; the ends never wrap.
  always_comb
    nxt = (inc && !dec) ? ((cnt == CNT_MAX) ? cnt : cnt + 2'd1) :
          (dec && !inc) ? ((cnt == CNT_MIN) ? cnt : cnt - 2'd1) : cnt;

endmodule

// File: rtl/branch_chooser.sv
// branch_chooser: tournament chooser selecting predictor 1 or 2 from a PC-indexed counter table
module branch_chooser
  import branch_chooser_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_VAL = CNT_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        predict1,
  input  logic        predict2,
  output logic        pprediction,
  output logic        pred_sel,
  output logic        pred_valid,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken1,
  input  logic        upd_taken2,
  output logic        ready
);

  localparam int DEPTH = 1 << IDX_W;

  state_t           state;
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic [1:0]       tbl [0:DEPTH-1];
  logic [1:0]       u_cnt;
  logic [1:0]       u_nxt;
  logic             f_sel;

  assign f_idx = IDX_W'(pc_index(fetch_pc));
  assign u_idx = IDX_W'(pc_index(upd_pc));
  assign u_cnt = tbl[u_idx];

  // While initialising the table is not trusted, so lookups fall back to predictor 1.
  assign f_sel = (state == ST_RUN) && tbl[f_idx][1];

  sat_counter2 u_sat (
    .cnt(u_cnt),
    .inc(upd_taken1),
    .dec(upd_taken2),
    .nxt(u_nxt)
  );

  // Sequencer and registered lookup outputs; flush restarts the clear sweep from entry 0.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      pprediction <= 1'b0;
      pred_sel    <= 1'b0;
      pred_valid  <= 1'b0;
      ready       <= 1'b0;
    end else begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_sel    <= f_sel;
        pprediction <= f_sel ? predict2 : predict1;
      end
      if (flush) begin
        state    <= ST_INIT;
        init_idx <= '0;
        ready    <= 1'b0;
      end else if (state == ST_INIT) begin
        init_idx <= init_idx + 1'b1;
        if (&init_idx) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      end
    end

  // Single write port: the clear sweep owns it in INIT, training owns it in RUN unless a flush drops it.
  always_ff @(posedge clk)
    if (state == ST_INIT) tbl[init_idx] <= INIT_VAL;
    else if (upd_valid && !flush) tbl[u_idx] <= u_nxt;

endmodule

// File: tb/tb_branch_chooser.sv
// tb_branch_chooser: directed-vector bench for branch_chooser
module tb_branch_chooser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        predict1 = 1'b0;
  logic        predict2 = 1'b0;
  logic        pprediction;
  logic        pred_sel;
  logic        pred_valid;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken1 = 1'b0;
  logic        upd_taken2 = 1'b0;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;
  int cnt;

  branch_chooser dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .predict1(predict1),
    .predict2(predict2),
    .pprediction(pprediction),
    .pred_sel(pred_sel),
    .pred_valid(pred_valid),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken1(upd_taken1),
    .upd_taken2(upd_taken2),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic p1, input logic p2);
    fetch_valid = 1'b1;
    fetch_pc = pc;
    predict1 = p1;
    predict2 = p2;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t1, input logic t2);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken1 = t1;
    upd_taken2 = t2;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_valid", pred_valid, 1'b0);
    chk("rst_pp", pprediction, 1'b0);
    chk("rst_sel", pred_sel, 1'b0);
    rst = 1'b0;
    fetch(32'h100, 1'b1, 1'b0);
    chk("init_valid", pred_valid, 1'b1);
    chk("init_pp", pprediction, 1'b1);
    chk("init_sel", pred_sel, 1'b0);
    chk("init_ready", ready, 1'b0);
    tick();
    chk("idle_valid", pred_valid, 1'b0);
    chk("idle_pp_hold", pprediction, 1'b1);
    for (int i = 0; i < 61; i++) tick();
    chk("ready_63", ready, 1'b0);
    tick();
    chk("ready_64", ready, 1'b1);
    fetch(32'h100, 1'b0, 1'b1);
    chk("dflt_sel", pred_sel, 1'b0);
    chk("dflt_pp", pprediction, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    fetch(32'h100, 1'b0, 1'b1);
    chk("p2_sel", pred_sel, 1'b1);
    chk("p2_pp", pprediction, 1'b1);
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b0, 1'b1);
    fetch(32'h100, 1'b1, 1'b0);
    chk("sat_hi_sel", pred_sel, 1'b1);
    chk("sat_hi_pp", pprediction, 1'b0);
    upd(32'h100, 1'b0, 1'b1);
    upd(32'h100, 1'b0, 1'b1);
    upd(32'h100, 1'b0, 1'b1);
    fetch(32'h100, 1'b1, 1'b0);
    chk("lo_sel", pred_sel, 1'b0);
    chk("lo_pp", pprediction, 1'b1);
    upd(32'h100, 1'b1, 1'b1);
    upd(32'h100, 1'b1, 1'b1);
    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    fetch(32'h100, 1'b0, 1'b1);
    chk("hold_sel", pred_sel, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    fetch(32'h100, 1'b0, 1'b1);
    chk("hold_sel2", pred_sel, 1'b1);
    fetch_valid = 1'b1;
    fetch_pc = 32'h104;
    predict1 = 1'b0;
    predict2 = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h104;
    upd_taken1 = 1'b1;
    upd_taken2 = 1'b0;
    tick();
    fetch_valid = 1'b0;
    upd_valid = 1'b0;
    chk("rbw_sel", pred_sel, 1'b0);
    chk("rbw_pp", pprediction, 1'b0);
    fetch(32'h104, 1'b0, 1'b1);
    chk("rbw_next_sel", pred_sel, 1'b1);
    upd(32'h004, 1'b0, 1'b1);
    upd(32'h004, 1'b0, 1'b1);
    fetch(32'h104, 1'b0, 1'b1);
    chk("alias_lo_sel", pred_sel, 1'b0);
    upd(32'h004, 1'b1, 1'b0);
    upd(32'h004, 1'b1, 1'b0);
    upd(32'h004, 1'b1, 1'b0);
    fetch(32'h104, 1'b0, 1'b1);
    chk("alias_hi_sel", pred_sel, 1'b1);
    flush = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h0fc;
    upd_taken1 = 1'b1;
    upd_taken2 = 1'b0;
    tick();
    flush = 1'b0;
    upd_valid = 1'b0;
    chk("flush_ready", ready, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 1'b0);
    fetch(32'h104, 1'b0, 1'b1);
    chk("flush_init_sel", pred_sel, 1'b0);
    for (int i = 0; i < 57; i++) tick();
    chk("flush_ready_63", ready, 1'b0);
    tick();
    chk("flush_ready_64", ready, 1'b1);
    fetch(32'h100, 1'b0, 1'b1);
    chk("flush_idx0_sel", pred_sel, 1'b0);
    fetch(32'h104, 1'b0, 1'b1);
    chk("flush_idx1_sel", pred_sel, 1'b0);
    fetch(32'h0fc, 1'b0, 1'b1);
    chk("flush_idx63_sel", pred_sel, 1'b0);
    upd(32'h0fc, 1'b1, 1'b0);
    fetch(32'h0fc, 1'b0, 1'b1);
    chk("flush_val01_sel", pred_sel, 1'b1);
    chk("pre_rst_pp", pprediction, 1'b1);
    chk("pre_rst_valid", pred_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pp", pprediction, 1'b0);
    chk("arst_sel", pred_sel, 1'b0);
    chk("arst_valid", pred_valid, 1'b0);
    chk("arst_ready", ready, 1'b0);
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    vectors++;
    assert (cnt == 64)
    else begin
      miscompares++;
      $error("FAIL rst_init_len: observed %0d expected 64", cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
